// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer: FSM states, loop-setting bundle
// and its power-on defaults.
package pll_ctrl_pkg;

    localparam int unsigned ICP_W    = 6;
    localparam int unsigned LPFRES_W = 3;
    localparam int unsigned LPFCAP_W = 2;
    localparam int unsigned RETRY_W  = 2;

    typedef enum logic [2:0] {
        RST,
        WAIT_LOCK,
        STABLE,
        LOCKED,
        FAIL
    } state_e;

    typedef struct packed {
        logic [ICP_W-1:0]    icp;
        logic [LPFRES_W-1:0] lpfres;
        logic [LPFCAP_W-1:0] lpfcap;
    } loop_cfg_t;

    localparam logic [ICP_W-1:0]    ICP_DEF    = 6'd16;
    localparam logic [LPFRES_W-1:0] LPFRES_DEF = 3'd2;
    localparam logic [LPFCAP_W-1:0] LPFCAP_DEF = 2'd0;

    localparam loop_cfg_t LOOP_DEF = '{icp: ICP_DEF, lpfres: LPFRES_DEF, lpfcap: LPFCAP_DEF};

    // Counter width wide enough for the longest of the three phase lengths (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Loop-settings request channel: a valid/ready handshake carrying new icpsel/lpfres/lpfcap.
interface pll_lock_ctrl_if;
    import pll_ctrl_pkg::*;

    logic                cfg_valid;
    logic [ICP_W-1:0]    cfg_icp;
    logic [LPFRES_W-1:0] cfg_lpfres;
    logic [LPFCAP_W-1:0] cfg_lpfcap;
    logic                cfg_ready;

    modport master (output cfg_valid, cfg_icp, cfg_lpfres, cfg_lpfcap, input cfg_ready);
    modport slave  (input cfg_valid, cfg_icp, cfg_lpfres, cfg_lpfcap, output cfg_ready);

endinterface

// File: rtl/pll_lock_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level, async active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_reset, qualifies synchronised lock, raises pll_ready,
// retries on timeout and applies new loop settings by re-running the sequence.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pll_lock,
    pll_lock_ctrl_if.slave      cfg_if,
    output logic                pll_reset,
    output logic [ICP_W-1:0]    icpsel,
    output logic [LPFRES_W-1:0] lpfres,
    output logic [LPFCAP_W-1:0] lpfcap,
    output logic                pll_ready,
    output logic                pll_fail,
    output logic [RETRY_W-1:0]  retry_cnt
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    loop_cfg_t          loop_q, loop_d;
    logic               pll_reset_q, pll_reset_d;
    logic               pll_ready_q, pll_ready_d;
    logic               pll_fail_q, pll_fail_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               lock_s;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loop_d    = loop_q;
        retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

        unique case (state_q)
            RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (32'(retry_inc) >= MAX_RETRY) ? FAIL : RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                // A lock glitch here is not a failed attempt; just wait for lock again.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                // Lock loss wins over a simultaneous settings request.
                if (!lock_s) begin
                    state_d = RST;
                    cnt_d   = '0;
                end else if (cfg_if.cfg_valid && cfg_ready_q) begin
                    loop_d  = '{icp:    cfg_if.cfg_icp,
                                lpfres: cfg_if.cfg_lpfres,
                                lpfcap: cfg_if.cfg_lpfcap};
                    state_d = RST;
                    cnt_d   = '0;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RST;
                cnt_d   = '0;
            end
        endcase

        pll_reset_d = (state_d == RST) || (state_d == FAIL);
        pll_ready_d = (state_d == LOCKED);
        cfg_ready_d = (state_d == LOCKED);
        pll_fail_d  = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loop_q      <= LOOP_DEF;
            pll_reset_q <= 1'b1;
            pll_ready_q <= 1'b0;
            pll_fail_q  <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loop_q      <= loop_d;
            pll_reset_q <= pll_reset_d;
            pll_ready_q <= pll_ready_d;
            pll_fail_q  <= pll_fail_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign pll_reset        = pll_reset_q;
    assign icpsel           = loop_q.icp;
    assign lpfres           = loop_q.lpfres;
    assign lpfcap           = loop_q.lpfcap;
    assign pll_ready        = pll_ready_q;
    assign pll_fail         = pll_fail_q;
    assign retry_cnt        = retry_q;
    assign cfg_if.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: stimulus queues the expected output snapshots with
// their cycle numbers, a negedge monitor pops one each time any output changes.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic       pll_ready;
    logic       pll_fail;
    logic [1:0] retry_cnt;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        logic [16:0] v;
    } ev_t;

    ev_t exp_q[$];

    pll_lock_ctrl_if cfg_if ();

    pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .cfg_if    (cfg_if),
        .pll_reset (pll_reset),
        .icpsel    (icpsel),
        .lpfres    (lpfres),
        .lpfcap    (lpfcap),
        .pll_ready (pll_ready),
        .pll_fail  (pll_fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input logic [16:0] v);
        return $sformatf("rst=%b rdy=%b crdy=%b fail=%b retry=%0d icp=%0d res=%0d cap=%0d",
                         v[16], v[15], v[14], v[13], v[12:11], v[10:5], v[4:2], v[1:0]);
    endfunction

    // Expected snapshot at cycle c; cfg_ready is expected to track pll_ready.
    task automatic push(input int c, input logic rst, input logic rdy, input logic fail,
                        input logic [1:0] rt, input logic [5:0] icp, input logic [2:0] res,
                        input logic [1:0] cap);
        ev_t e;
        e.cyc = c;
        e.v   = {rst, rdy, rdy, fail, rt, icp, res, cap};
        exp_q.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: any output change is a DUT event to be matched against the scoreboard.
    logic [16:0] prev_v;
    bit          have_prev = 1'b0;

    always @(negedge clk) begin : mon
        logic [16:0] cur;
        ev_t         e;
        cur = {pll_reset, pll_ready, cfg_if.cfg_ready, pll_fail, retry_cnt,
               icpsel, lpfres, lpfcap};
        if (!have_prev || cur != prev_v) begin
            have_prev = 1'b1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event @%0d: got %s, required no change", cyc, fmt(cur));
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    n_err++;
                    $display("FAIL event: got @%0d %s, required @%0d %s",
                             cyc, fmt(cur), e.cyc, fmt(e.v));
                end
            end
        end
        prev_v = cur;
    end

    initial begin
        resetn            = 1'b0;
        pll_lock          = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_icp    = 6'd0;
        cfg_if.cfg_lpfres = 3'd0;
        cfg_if.cfg_lpfcap = 2'd0;

        // Power-up: reset values, 4-cycle reset pulse, lock 10 cycles after release.
        push(1,  1, 0, 0, 0, 16, 2, 0);
        push(6,  0, 0, 0, 0, 16, 2, 0);
        push(23, 0, 1, 0, 0, 16, 2, 0);
        goto(2);  resetn   = 1'b1;
        goto(12); pll_lock = 1'b1;

        // One-cycle lock dropout in LOCKED: re-run sequence, relock.
        goto(26);
        push(29, 1, 0, 0, 0, 16, 2, 0);
        push(33, 0, 0, 0, 0, 16, 2, 0);
        push(42, 0, 1, 0, 0, 16, 2, 0);
        pll_lock = 1'b0;
        goto(27); pll_lock = 1'b1;

        // New loop settings accepted in one cycle and visible while pll_reset is high.
        goto(45);
        push(46, 1, 0, 0, 0, 40, 5, 1);
        push(50, 0, 0, 0, 0, 40, 5, 1);
        push(59, 0, 1, 0, 0, 40, 5, 1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_icp    = 6'd40;
        cfg_if.cfg_lpfres = 3'd5;
        cfg_if.cfg_lpfcap = 2'd1;
        goto(46); cfg_if.cfg_valid = 1'b0;

        // Request offered in the cycle lock loss is seen: not captured.
        goto(62);
        push(65, 1, 0, 0, 0, 40, 5, 1);
        push(69, 0, 0, 0, 0, 40, 5, 1);
        push(78, 0, 1, 0, 0, 40, 5, 1);
        pll_lock = 1'b0;
        goto(63); pll_lock = 1'b1;
        goto(64);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_icp    = 6'd7;
        cfg_if.cfg_lpfres = 3'd1;
        cfg_if.cfg_lpfcap = 2'd3;
        goto(65); cfg_if.cfg_valid = 1'b0;

        // Async reset while LOCKED, then a lock glitch in STABLE at cnt=5.
        goto(80);
        push(81,  1, 0, 0, 0, 16, 2, 0);
        push(85,  0, 0, 0, 0, 16, 2, 0);
        push(104, 0, 1, 0, 0, 16, 2, 0);
        #2;
        resetn   = 1'b0;
        pll_lock = 1'b0;
        goto(81); resetn   = 1'b1;
        goto(86); pll_lock = 1'b1;
        goto(92); pll_lock = 1'b0;
        goto(93); pll_lock = 1'b1;

        // No lock at all: three attempts, then sticky FAIL.
        goto(106);
        push(107, 1, 0, 0, 0, 16, 2, 0);
        push(111, 0, 0, 0, 0, 16, 2, 0);
        push(143, 1, 0, 0, 1, 16, 2, 0);
        push(147, 0, 0, 0, 1, 16, 2, 0);
        push(179, 1, 0, 0, 2, 16, 2, 0);
        push(183, 0, 0, 0, 2, 16, 2, 0);
        push(215, 1, 0, 1, 3, 16, 2, 0);
        #2;
        resetn   = 1'b0;
        pll_lock = 1'b0;
        goto(107); resetn = 1'b1;

        // FAIL ignores late lock and settings requests.
        goto(230); pll_lock = 1'b1;
        goto(240);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_icp    = 6'd63;
        cfg_if.cfg_lpfres = 3'd7;
        cfg_if.cfg_lpfcap = 2'd3;
        goto(243); cfg_if.cfg_valid = 1'b0;

        goto(270);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: %0d still queued, required 0 (next @%0d %s)",
                     exp_q.size(), exp_q[0].cyc, fmt(exp_q[0].v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
